perf_counter_sequencer: RTL and testbench



---
 rtl/perf_counter_sequencer.sv | 164 ++++++++++++++++
 tb/tb_perf_counter_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_sequencer.sv
// Round-robin sequencer that turns per-requester section commands into single-beat
// Avalon-MM writes to the counter control slave and tracks which sections run.
module perf_counter_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int SECT_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [SECT_W*NUM_REQ-1:0] req_section,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [4:0]                avm_address,
  output logic                      avm_write,
  output logic                      avm_begintransfer,
  output logic [31:0]               avm_writedata,
  input  logic                      avm_waitrequest,
  output logic [7:0]                active_mask,
  output logic                      err_sticky,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [1:0] OP_BEGIN = 2'b00;
  localparam logic [1:0] OP_END   = 2'b01;
  localparam logic [1:0] OP_GRST  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t            state_q, state_d;
  logic [2:0]        last_q, last_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic [1:0]        op_q, op_d;
  logic [SECT_W-1:0] section_q, section_d;
  logic [4:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              first_q, first_d;
  logic [7:0]        active_mask_q, active_mask_d;
  logic              err_q, err_d;

  logic               grant_valid;
  logic [2:0]         grant_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic [1:0]         sel_op;
  logic [SECT_W-1:0]  sel_section;
  logic [3:0]         cand;

  // Search starts one past the last winner, wrapping at NUM_REQ.
  always_comb begin : arbiter
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    sel_op      = '0;
    sel_section = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_valid && cand == 4'(i) && req_valid[i]) begin
          grant_valid  = 1'b1;
          grant_idx    = 3'(i);
          grant_vec[i] = 1'b1;
          sel_op       = req_op[2*i +: 2];
          sel_section  = req_section[SECT_W*i +: SECT_W];
        end
      end
    end
  end

  always_comb begin : next_state
    state_d       = state_q;
    last_d        = last_q;
    grant_id_d    = grant_id_q;
    op_d          = op_q;
    section_d     = section_q;
    addr_d        = addr_q;
    data_d        = data_q;
    first_d       = first_q;
    active_mask_d = active_mask_q;
    err_d         = err_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_ready  = reset ? '0 : grant_vec;
          last_d     = grant_idx;
          grant_id_d = grant_idx;
          op_d       = sel_op;
          section_d  = sel_section;
          case (sel_op)
            OP_BEGIN: begin addr_d = 5'({sel_section, 2'b01}); data_d = 32'd0; end
            OP_END:   begin addr_d = 5'({sel_section, 2'b00}); data_d = 32'd0; end
            OP_GRST:  begin addr_d = 5'd0;                     data_d = 32'd1; end
            default:  ;
          endcase
          // Reserved opcode is consumed without touching the bus.
          if (sel_op == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            state_d = WRITE;
            first_d = 1'b1;
          end
        end
      end
      WRITE: begin
        first_d = 1'b0;
        if (!avm_waitrequest) begin
          state_d = IDLE;
          case (op_q)
            OP_BEGIN: begin
              if (active_mask_q[section_q]) err_d = 1'b1;
              active_mask_d[section_q] = 1'b1;
            end
            OP_END: begin
              if (!active_mask_q[section_q]) err_d = 1'b1;
              active_mask_d[section_q] = 1'b0;
            end
            OP_GRST: active_mask_d = '0;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 3'(NUM_REQ - 1);
      grant_id_q    <= '0;
      op_q          <= '0;
      section_q     <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      first_q       <= 1'b0;
      active_mask_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_id_q    <= grant_id_d;
      op_q          <= op_d;
      section_q     <= section_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      first_q       <= first_d;
      active_mask_q <= active_mask_d;
      err_q         <= err_d;
    end
  end

  assign avm_write         = (state_q == WRITE);
  assign busy              = (state_q == WRITE);
  assign avm_begintransfer = (state_q == WRITE) && first_q;
  assign avm_address       = addr_q;
  assign avm_writedata     = data_q;
  assign active_mask       = active_mask_q;
  assign err_sticky        = err_q;
  assign grant_id          = grant_id_q;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Bench for perf_counter_sequencer: directed scenarios plus a randomized run
// checked against a command-level reference model.
`timescale 1ns/1ps
module tb_perf_counter_sequencer;

  localparam int NUM_REQ = 4;
  localparam int SECT_W  = 3;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [SECT_W*NUM_REQ-1:0] req_section;
  logic [NUM_REQ-1:0]        req_ready;
  logic [4:0]                avm_address;
  logic                      avm_write;
  logic                      avm_begintransfer;
  logic [31:0]               avm_writedata;
  logic                      avm_waitrequest;
  logic [7:0]                active_mask;
  logic                      err_sticky;
  logic [2:0]                grant_id;
  logic                      busy;

  int n_checks = 0;
  int n_fail   = 0;

  perf_counter_sequencer #(.NUM_REQ(NUM_REQ), .SECT_W(SECT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_op            (req_op),
    .req_section       (req_section),
    .req_ready         (req_ready),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_begintransfer (avm_begintransfer),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .active_mask       (active_mask),
    .err_sticky        (err_sticky),
    .grant_id          (grant_id),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input bit v, input logic [1:0] op, input logic [2:0] sec);
    req_valid[i]            = v;
    req_op[2*i +: 2]        = op;
    req_section[3*i +: 3]   = sec;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; avm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Posts one command, waits for its accept, then follows the bus write.
  task automatic issue(input int id, input logic [1:0] op, input logic [2:0] sec, input int stall,
                       output int acc_wait, output logic [4:0] addr, output logic [31:0] data,
                       output int nwr, output int nbt, output bit bt_first, output bit stable);
    acc_wait = -1; addr = '0; data = '0; nwr = 0; nbt = 0; bt_first = 0; stable = 1;
    @(negedge clk);
    set_req(id, 1, op, sec);
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req_ready[id]) begin acc_wait = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    set_req(id, 0, op, sec);
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      avm_waitrequest = (c < stall);
      #1;
      if (!avm_write) break;
      if (nwr == 0) begin addr = avm_address; data = avm_writedata; bt_first = avm_begintransfer; end
      else if (avm_address !== addr || avm_writedata !== data) stable = 0;
      if (avm_begintransfer) nbt++;
      nwr++;
    end
    avm_waitrequest = 1'b0;
    $display("txn: req %0d op %b sec %0d stall %0d -> accept_wait %0d addr %0d data %0h beats %0d mask %h err %b",
             id, op, sec, stall, acc_wait, addr, data, nwr, active_mask, err_sticky);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '1; avm_waitrequest = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_checks++; if (avm_write !== 1'b0 || busy !== 1'b0 || avm_begintransfer !== 1'b0) begin n_fail++; $display("FAIL reset_bus: write %b busy %b bt %b expected 0", avm_write, busy, avm_begintransfer); end
    n_checks++; if (avm_address !== 5'd0 || avm_writedata !== 32'd0) begin n_fail++; $display("FAIL reset_addr: addr %0d data %0h expected 0", avm_address, avm_writedata); end
    n_checks++; if (active_mask !== 8'h00 || err_sticky !== 1'b0 || grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_state: mask %h err %b gid %0d expected 0", active_mask, err_sticky, grant_id); end
    $display("txn: reset held, outputs mask %h err %b", active_mask, err_sticky);
    @(negedge clk);
    req_valid = '0; reset = 1'b0;
  endtask

  task automatic test_begin_basic();
    do_reset();
    @(negedge clk);
    set_req(0, 1, 2'b00, 3'd2); avm_waitrequest = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_ready: got %b expected 0001", req_ready); end
    @(negedge clk);
    set_req(0, 0, 2'b00, 3'd2);
    #1;
    n_checks++; if (avm_write !== 1'b1 || avm_begintransfer !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_write: write %b bt %b busy %b expected 1 1 1", avm_write, avm_begintransfer, busy); end
    n_checks++; if (avm_address !== 5'd9 || avm_writedata !== 32'd0) begin n_fail++; $display("FAIL basic_addr: addr %0d data %0h expected 9 0", avm_address, avm_writedata); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL basic_ready_in_write: got %b expected 0000", req_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (avm_write !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: write %b busy %b expected 0 0", avm_write, busy); end
    n_checks++; if (active_mask !== 8'h04 || grant_id !== 3'd0) begin n_fail++; $display("FAIL basic_mask: mask %h gid %0d expected 04 0", active_mask, grant_id); end
    $display("txn: req 0 BEGIN sec 2 -> mask %h", active_mask);
  endtask

  task automatic test_end_stall();
    int aw, nwr, nbt; logic [4:0] a; logic [31:0] d; bit btf, st;
    issue(1, 2'b01, 3'd2, 3, aw, a, d, nwr, nbt, btf, st);
    n_checks++; if (aw !== 0) begin n_fail++; $display("FAIL stall_accept: wait %0d expected 0", aw); end
    n_checks++; if (nwr !== 4) begin n_fail++; $display("FAIL stall_beats: got %0d expected 4", nwr); end
    n_checks++; if (nbt !== 1 || btf !== 1'b1) begin n_fail++; $display("FAIL stall_bt: count %0d first %b expected 1 1", nbt, btf); end
    n_checks++; if (a !== 5'd8 || d !== 32'd0 || st !== 1'b1) begin n_fail++; $display("FAIL stall_addr: addr %0d data %0h stable %b expected 8 0 1", a, d, st); end
    n_checks++; if (active_mask !== 8'h00 || grant_id !== 3'd1 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL stall_mask: mask %h gid %0d err %b expected 00 1 0", active_mask, grant_id, err_sticky); end
  endtask

  task automatic test_back_to_back();
    int gid[4]; int gcyc[4]; int addrs[4]; int ng, na, lastg;
    do_reset();
    for (int k = 0; k < 4; k++) begin gid[k] = -1; gcyc[k] = -10; addrs[k] = -1; end
    ng = 0; na = 0;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 2'b00, 3'(4 + i));
    avm_waitrequest = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      lastg = -1;
      if (req_ready !== 4'b0000) begin
        n_checks++; if ($countones(req_ready) != 1) begin n_fail++; $display("FAIL b2b_onehot: ready %b expected one bit", req_ready); end
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) lastg = i;
        if (ng < 4) begin gid[ng] = lastg; gcyc[ng] = cyc; end
        ng++;
      end
      if (avm_write && avm_begintransfer) begin
        if (na < 4) addrs[na] = int'(avm_address);
        na++;
      end
      @(negedge clk);
      if (lastg >= 0) set_req(lastg, 0, 2'b00, 3'd0);
    end
    #1;
    n_checks++; if (ng !== 4 || na !== 4) begin n_fail++; $display("FAIL b2b_count: grants %0d writes %0d expected 4 4", ng, na); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (gid[k] !== k) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", k, gid[k], k); end
      n_checks++; if (addrs[k] !== 17 + 4*k) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", k, addrs[k], 17 + 4*k); end
      if (k > 0) begin
        n_checks++; if (gcyc[k] - gcyc[k-1] !== 2) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 2", k, gcyc[k] - gcyc[k-1]); end
      end
      $display("txn: b2b grant %0d at cycle %0d addr %0d", gid[k], gcyc[k], addrs[k]);
    end
    n_checks++; if (active_mask !== 8'hF0) begin n_fail++; $display("FAIL b2b_mask: got %h expected f0", active_mask); end
  endtask

  task automatic test_global_reset();
    int aw, nwr, nbt; logic [4:0] a; logic [31:0] d; bit btf, st;
    issue(3, 2'b10, 3'd5, 0, aw, a, d, nwr, nbt, btf, st);
    n_checks++; if (a !== 5'd0 || d !== 32'h00000001 || nwr !== 1) begin n_fail++; $display("FAIL grst_write: addr %0d data %0h beats %0d expected 0 1 1", a, d, nwr); end
    n_checks++; if (active_mask !== 8'h00 || grant_id !== 3'd3) begin n_fail++; $display("FAIL grst_mask: mask %h gid %0d expected 00 3", active_mask, grant_id); end
  endtask

  task automatic test_misuse();
    int aw, nwr, nbt; logic [4:0] a; logic [31:0] d; bit btf, st;
    issue(2, 2'b01, 3'd1, 1, aw, a, d, nwr, nbt, btf, st);
    n_checks++; if (a !== 5'd4 || nwr !== 2) begin n_fail++; $display("FAIL misuse_end_write: addr %0d beats %0d expected 4 2", a, nwr); end
    n_checks++; if (err_sticky !== 1'b1 || active_mask !== 8'h00) begin n_fail++; $display("FAIL misuse_end_err: err %b mask %h expected 1 00", err_sticky, active_mask); end
    do_reset();
    #1;
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL misuse_err_clear: got %b expected 0", err_sticky); end
    issue(0, 2'b11, 3'd5, 0, aw, a, d, nwr, nbt, btf, st);
    n_checks++; if (aw !== 0 || nwr !== 0) begin n_fail++; $display("FAIL misuse_rsvd: accept_wait %0d beats %0d expected 0 0", aw, nwr); end
    n_checks++; if (err_sticky !== 1'b1 || active_mask !== 8'h00) begin n_fail++; $display("FAIL misuse_rsvd_err: err %b mask %h expected 1 00", err_sticky, active_mask); end
  endtask

  task automatic test_reset_in_write();
    int aw, nwr, nbt; logic [4:0] a; logic [31:0] d; bit btf, st;
    issue(2, 2'b00, 3'd3, 0, aw, a, d, nwr, nbt, btf, st);
    n_checks++; if (active_mask !== 8'h08) begin n_fail++; $display("FAIL rstw_pre_mask: got %h expected 08", active_mask); end
    @(negedge clk);
    set_req(1, 1, 2'b00, 3'd5); avm_waitrequest = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rstw_ready: got %b expected 0010", req_ready); end
    @(negedge clk);
    set_req(1, 0, 2'b00, 3'd5);
    #1;
    n_checks++; if (avm_write !== 1'b1) begin n_fail++; $display("FAIL rstw_stalled: write %b expected 1", avm_write); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; avm_waitrequest = 1'b0;
    #1;
    n_checks++; if (avm_write !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_abandon: write %b busy %b expected 0 0", avm_write, busy); end
    n_checks++; if (active_mask !== 8'h00 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL rstw_clear: mask %h err %b expected 00 0", active_mask, err_sticky); end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 2'b00, 3'd0);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstw_restart: ready %b expected 0001", req_ready); end
    $display("txn: reset during stalled write -> mask %h, next grant %b", active_mask, req_ready);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    bit pv[NUM_REQ]; logic [1:0] pop[NUM_REQ]; logic [2:0] psec[NUM_REQ];
    int m_last, m_gid, m_addr, m_data, m_sec, done, g, r;
    logic [1:0] m_op; bit [7:0] m_mask; bit m_err, m_busy, m_first;
    logic [NUM_REQ-1:0] exp_ready;
    do_reset();
    m_last = NUM_REQ - 1; m_mask = '0; m_err = 0; m_busy = 0; m_first = 0; done = 0;
    m_gid = 0; m_addr = 0; m_data = 0; m_sec = 0; m_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin pv[i] = 0; pop[i] = '0; psec[i] = '0; end
    for (int cyc = 0; cyc < 2000 && done < 100; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1; r = $urandom_range(0, 15);
          pop[i] = (r == 0) ? 2'b11 : 2'(r % 3);
          psec[i] = 3'($urandom_range(0, 7));
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 0;
        end
        set_req(i, pv[i], pop[i], psec[i]);
      end
      avm_waitrequest = 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (active_mask !== m_mask) begin n_fail++; $display("FAIL rnd_mask cyc %0d: got %h expected %h", cyc, active_mask, m_mask); end
      n_checks++; if (err_sticky !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %b expected %b", cyc, err_sticky, m_err); end
      if (!m_busy) begin
        g = -1;
        for (int k = 1; k <= NUM_REQ; k++)
          if (g < 0 && pv[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        n_checks++; if (req_ready !== exp_ready || avm_write !== 1'b0) begin n_fail++; $display("FAIL rnd_grant cyc %0d: ready %b write %b expected %b 0", cyc, req_ready, avm_write, exp_ready); end
        if (g >= 0) begin
          m_last = g; pv[g] = 0; done++;
          m_op = pop[g]; m_sec = int'(psec[g]); m_gid = g;
          if (m_op == 2'b11) begin
            m_err = 1;
          end else begin
            m_busy = 1; m_first = 1;
            m_addr = (m_op == 2'b00) ? m_sec*4 + 1 : (m_op == 2'b01) ? m_sec*4 : 0;
            m_data = (m_op == 2'b10) ? 1 : 0;
          end
          $display("txn: rnd grant req %0d op %b sec %0d", g, m_op, m_sec);
        end
      end else begin
        n_checks++;
        if (req_ready !== 4'b0000 || avm_write !== 1'b1 || int'(avm_address) !== m_addr ||
            int'(avm_writedata) !== m_data || avm_begintransfer !== m_first || int'(grant_id) !== m_gid) begin
          n_fail++;
          $display("FAIL rnd_write cyc %0d: ready %b write %b addr %0d data %0h bt %b gid %0d expected 0000 1 %0d %0h %b %0d",
                   cyc, req_ready, avm_write, avm_address, avm_writedata, avm_begintransfer, grant_id, m_addr, m_data, m_first, m_gid);
        end
        m_first = 0;
        if (!avm_waitrequest) begin
          m_busy = 0;
          case (m_op)
            2'b00: begin if (m_mask[m_sec]) m_err = 1; m_mask[m_sec] = 1'b1; end
            2'b01: begin if (!m_mask[m_sec]) m_err = 1; m_mask[m_sec] = 1'b0; end
            2'b10: m_mask = '0;
            default: ;
          endcase
        end
      end
    end
    n_checks++; if (done < 100) begin n_fail++; $display("FAIL rnd_budget: commands %0d expected 100", done); end
    @(negedge clk);
    req_valid = '0; avm_waitrequest = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_section = '0; avm_waitrequest = 1'b0;
    test_reset();
    test_begin_basic();
    test_end_stall();
    test_back_to_back();
    test_global_reset();
    test_misuse();
    test_reset_in_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
